inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue_if.sv | 24 ++
 rtl/inst_fetch_queue.sv | 97 +++++++++
 tb/tb_inst_fetch_queue.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-unit bus bundle: decode-side control, instruction memory port and queue head.
// The master modport is the fetch queue itself; slave is the decode stage / memory side.
interface inst_fetch_queue_if;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  modport master (
    input  stall_i, flush_i, flush_addr_i, imem_ack_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, pc_o, inst_o, inst_valid_o
  );

  modport slave (
    output stall_i, flush_i, flush_addr_i, imem_ack_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, pc_o, inst_o, inst_valid_o
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: one outstanding memory request feeding a small circular queue.
// A redirect while a request is in flight turns that request into a discarded one.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_queue_if.master bus
);
  localparam int unsigned    PTR_W = $clog2(QDEPTH);
  localparam int unsigned    CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]      pc_mem   [QDEPTH];
  logic [31:0]      inst_mem [QDEPTH];
  logic             push, pop, qvalid;
  logic [31:0]      flush_pc;

  assign flush_pc = {bus.flush_addr_i[31:2], 2'b00};
  assign qvalid   = (count_q != '0);
  assign push     = (state_q == WAIT) && bus.imem_ack_i && !bus.flush_i;
  assign pop      = qvalid && !bus.stall_i && !bus.flush_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        // A redirect cycle never issues; the new target goes out next cycle.
        if (bus.flush_i) begin
          fetch_pc_d = flush_pc;
        end else if (count_q < FULL) begin
          state_d    = WAIT;
          addr_d     = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (bus.imem_ack_i)   state_d = IDLE;
        else if (bus.flush_i) state_d = DROP;
        if (bus.flush_i) fetch_pc_d = flush_pc;
      end
      DROP: begin
        if (bus.imem_ack_i) state_d = IDLE;
        if (bus.flush_i)    fetch_pc_d = flush_pc;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  // Queue control; a redirect empties the queue regardless of push/pop.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= addr_q;
      inst_mem[wr_ptr_q] <= bus.imem_rdata_i;
    end
  end

  assign bus.imem_req_o   = (state_q != IDLE);
  assign bus.imem_addr_o  = addr_q;
  assign bus.inst_valid_o = qvalid;
  assign bus.pc_o         = qvalid ? pc_mem[rd_ptr_q]   : 32'd0;
  assign bus.inst_o       = qvalid ? inst_mem[rd_ptr_q] : 32'd0;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: reset/throughput vector table, directed redirect and
// full-queue sequences, then random traffic against a transaction-level queue model.
module tb_inst_fetch_queue;
  logic clk;
  logic rst;
  inst_fetch_queue_if bus();

  inst_fetch_queue #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct {
    logic        r, s, f;
    logic [31:0] fa;
    logic        a;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  int passed = 0;
  int total  = 0;
  int req_cnt = 0;

  // Reference model: one optional in-flight fetch and a FIFO of delivered words.
  logic        m_out, m_disc;
  logic [31:0] m_fpc, m_addr;
  entry_t      q[$];

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic model_update(input logic r, s, f, input logic [31:0] fa,
                              input logic a, input logic [31:0] rd);
    logic pop, do_push;
    if (r) begin
      m_out = 1'b0; m_disc = 1'b0; m_fpc = 32'h0; m_addr = 32'h0;
      q.delete();
      return;
    end
    pop     = (q.size() != 0) && !s && !f;
    do_push = 1'b0;
    if (m_out) begin
      if (a) begin
        do_push = !m_disc && !f;
        m_out   = 1'b0;
      end else if (f) begin
        m_disc = 1'b1;
      end
      if (f) m_fpc = fa & 32'hFFFF_FFFC;
    end else begin
      if (f) m_fpc = fa & 32'hFFFF_FFFC;
      else if (q.size() < 4) begin
        m_out = 1'b1; m_disc = 1'b0; m_addr = m_fpc; m_fpc = m_fpc + 32'd4;
      end
    end
    if (f) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (do_push) q.push_back('{pc: m_addr, inst: rd});
    end
  endtask

  task automatic compare_model();
    chk("req",   {31'd0, bus.imem_req_o},   {31'd0, m_out});
    chk("addr",  bus.imem_addr_o,           m_addr);
    chk("valid", {31'd0, bus.inst_valid_o}, {31'd0, q.size() != 0});
    chk("pc",    bus.pc_o,   (q.size() != 0) ? q[0].pc   : 32'd0);
    chk("inst",  bus.inst_o, (q.size() != 0) ? q[0].inst : 32'd0);
  endtask

  // Called at a falling edge: drive inputs, advance the model, clock, compare.
  task automatic step(input logic r, s, f, input logic [31:0] fa, input logic a);
    logic [31:0] rd;
    rd = mem_data(bus.imem_addr_o);
    rst = r;
    bus.stall_i = s; bus.flush_i = f; bus.flush_addr_i = fa;
    bus.imem_ack_i = a; bus.imem_rdata_i = rd;
    if (a && bus.imem_req_o && !r) req_cnt++;
    model_update(r, s, f, fa, a, rd);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic fetch_n(input int n, input logic s);
    for (int i = 0; i < n; i++) begin
      step(1'b0, s, 1'b0, 32'h0, 1'b0);
      step(1'b0, s, 1'b0, 32'h0, 1'b1);
    end
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 1'b1, 32'h4};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 1'b1, 32'h8};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0};

    rst = 1'b1;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.flush_addr_i = 32'h0;
    bus.imem_ack_i = 1'b0; bus.imem_rdata_i = 32'h0;
    m_out = 1'b0; m_disc = 1'b0; m_fpc = 32'h0; m_addr = 32'h0;
    @(negedge clk);

    // Reset, back-to-back fetch, reset priority over flush/ack
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].fa, vecs[i].a);
      chk($sformatf("vec%0d_req", i),   {31'd0, bus.imem_req_o},   {31'd0, vecs[i].e_req});
      chk($sformatf("vec%0d_addr", i),  bus.imem_addr_o,           vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.inst_valid_o}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_pc", i),    bus.pc_o,                  vecs[i].e_pc);
    end

    // Stalled decode fills the queue, then pop+ack when three deep, order across wrap
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    req_cnt = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 32'h0, bus.imem_req_o);
    chk("full_reqs", req_cnt, 32'd4);
    chk("full_noreq", {31'd0, bus.imem_req_o}, 32'd0);
    chk("full_head", bus.pc_o, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("unstall_head", bus.pc_o, 32'h4);
    chk("unstall_noreq", {31'd0, bus.imem_req_o}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("refill_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("refill_addr", bus.imem_addr_o, 32'h10);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("pushpop_head", bus.pc_o, 32'h8);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("drain1", bus.pc_o, 32'hC);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("drain2", bus.pc_o, 32'h10);
    chk("drain2_inst", bus.inst_o, mem_data(32'h10));
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("drain3_empty", {31'd0, bus.inst_valid_o}, 32'd0);

    // Redirect while waiting on 0x8; late ack must be dropped
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch_n(2, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("drop_addr8", bus.imem_addr_o, 32'h8);
    step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
    chk("drop_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("drop_cleared", {31'd0, bus.inst_valid_o}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("drop_done_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("drop_not_queued", {31'd0, bus.inst_valid_o}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_addr", bus.imem_addr_o, 32'h100);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("redir_head", bus.pc_o, 32'h100);

    // Redirect coinciding with the ack for 0xC
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch_n(3, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("ackflush_addrC", bus.imem_addr_o, 32'hC);
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
    chk("ackflush_empty", {31'd0, bus.inst_valid_o}, 32'd0);
    chk("ackflush_idle", {31'd0, bus.imem_req_o}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("ackflush_next", bus.imem_addr_o, 32'h200);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Unaligned redirect near the top of memory, then address wrap
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0);
    chk("wrap_flush_noreq", {31'd0, bus.imem_req_o}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr_zero", bus.imem_addr_o, 32'h0);
    chk("wrap_req", {31'd0, bus.imem_req_o}, 32'd1);

    // Random traffic
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0,
           $urandom,
           bus.imem_req_o && ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
